// File: rtl/home_auto_pkg.sv
// Shared constants and helpers for the home automation event arbiter.
package home_auto_pkg;

    typedef int unsigned width_t;

    localparam width_t CODE_IDLE = 0;
    localparam width_t ALARM_CH  = 2;

    // Smallest r such that 2**r >= v.
    function automatic width_t clog2(input width_t v);
        width_t r;
        r = 0;
        while ((width_t'(1) << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/home_event_arbiter_priority_mode_counter.sv
// Activity counter; its MSB selects the arbitration priority direction.
module priority_mode_counter #(
    parameter int unsigned PERIOD_W = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    output logic rev_mode
);

    logic [PERIOD_W-1:0] cnt_q;
    logic [PERIOD_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc) begin
            cnt_d = cnt_q + PERIOD_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign rev_mode = cnt_q[PERIOD_W-1];

endmodule

// File: rtl/home_event_arbiter.sv
// One-grant-per-cycle event arbiter with alternating priority and minimum hold.
// Optional sticky alarm channel: define HOME_EVENT_ARBITER_STICKY_ALARM_EN.
module home_event_arbiter
    import home_auto_pkg::*;
#(
    parameter int unsigned N_REQ       = 5,
    parameter int unsigned TEMP_W      = 6,
    parameter int unsigned HEAT_TH     = 15,
    parameter int unsigned COOL_TH     = 30,
    parameter int unsigned PERIOD_W    = 4,
    parameter int unsigned HOLD_CYCLES = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [N_REQ-1:0]              req,
    input  logic                          temp_en,
    input  logic [TEMP_W-1:0]             temperature,
    input  logic                          ack_alarm,
    output logic [N_REQ+1:0]              grant_oh,
    output logic [clog2(N_REQ+3)-1:0]     code,
    output logic                          rev_mode
);

    localparam int unsigned N_CH   = N_REQ + 2;
    localparam int unsigned CODE_W = clog2(N_CH + 1);
    localparam int unsigned HOLD_W = 4;

    if (HEAT_TH > COOL_TH) begin : g_bad_thresholds
        $error("home_event_arbiter: HEAT_TH must not exceed COOL_TH");
    end
    if (HOLD_CYCLES < 1 || HOLD_CYCLES > 15) begin : g_bad_hold
        $error("home_event_arbiter: HOLD_CYCLES must be in 1..15");
    end

    logic [N_CH-1:0]   ch_c;
    logic              heat_req_c;
    logic              cool_req_c;
    logic [CODE_W-1:0] arb_code_c;
    logic              cur_req_c;
    logic              sticky_c;

    logic [CODE_W-1:0] code_q,  code_d;
    logic [N_CH-1:0]   grant_q, grant_d;
    logic [HOLD_W-1:0] hold_q,  hold_d;

    assign heat_req_c = temp_en && (32'(temperature) < HEAT_TH);
    assign cool_req_c = temp_en && (32'(temperature) > COOL_TH);
    assign ch_c       = {cool_req_c, heat_req_c, req};
    assign cur_req_c  = |(grant_q & ch_c);

`ifdef HOME_EVENT_ARBITER_STICKY_ALARM_EN
    if (N_REQ <= ALARM_CH) begin : g_bad_alarm
        $error("home_event_arbiter: sticky alarm needs N_REQ > ALARM_CH");
    end
    assign sticky_c = (code_q == CODE_W'(ALARM_CH + 1)) && !ack_alarm;
`else
    logic unused_ack_c;
    assign unused_ack_c = ack_alarm;
    assign sticky_c     = 1'b0;
`endif

    priority_mode_counter #(
        .PERIOD_W (PERIOD_W)
    ) u_mode_cnt (
        .clk      (clk),
        .reset    (reset),
        .inc      (|ch_c),
        .rev_mode (rev_mode)
    );

    // Winner scan: later assignments override, so scan order sets priority.
    always_comb begin
        arb_code_c = CODE_W'(CODE_IDLE);
        if (rev_mode) begin
            for (int i = 0; i < int'(N_CH); i++) begin
                if (ch_c[i]) arb_code_c = CODE_W'(i + 1);
            end
        end else begin
            for (int i = int'(N_CH) - 1; i >= 0; i--) begin
                if (ch_c[i]) arb_code_c = CODE_W'(i + 1);
            end
        end
    end

    always_comb begin
        code_d  = code_q;
        hold_d  = hold_q;
        grant_d = '0;
        if (sticky_c) begin
            code_d = code_q;
        end else if (code_q != CODE_W'(CODE_IDLE) && cur_req_c && hold_q != '0) begin
            hold_d = hold_q - HOLD_W'(1);
        end else begin
            code_d = arb_code_c;
            if (arb_code_c != CODE_W'(CODE_IDLE) && arb_code_c != code_q) begin
                hold_d = HOLD_W'(HOLD_CYCLES - 1);
            end else begin
                hold_d = '0;
            end
        end
        if (code_d != CODE_W'(CODE_IDLE)) begin
            grant_d = N_CH'(1) << (code_d - CODE_W'(1));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            code_q  <= '0;
            grant_q <= '0;
            hold_q  <= '0;
        end else begin
            code_q  <= code_d;
            grant_q <= grant_d;
            hold_q  <= hold_d;
        end
    end

    assign code     = code_q;
    assign grant_oh = grant_q;

endmodule

// File: doc/home_event_arbiter.md
Name: home_event_arbiter

Overview:
- Parametrised next-generation event arbiter for the home automation controller.
- Accepts N_REQ binary sensor requests plus a temperature input that generates heat and cool requests.
- Grants exactly one channel per cycle. Priority direction alternates under an activity counter. Grants have a minimum hold time.
- Drives a registered one-hot actuator vector and a binary display code, consumed by the actuator/display stage.

Parameters:
- N_REQ, 5: number of binary sensor request lines. Index 0 has the highest priority in normal mode.
- TEMP_W, 6: width of the unsigned temperature input.
- HEAT_TH, 15: heat request asserted when temp_en=1 and temperature < HEAT_TH.
- COOL_TH, 30: cool request asserted when temp_en=1 and temperature > COOL_TH. Requires HEAT_TH <= COOL_TH; violating this is an elaboration error.
- PERIOD_W, 4: width of the activity counter. Priority is reversed while the counter MSB is 1.
- HOLD_CYCLES, 2: minimum number of cycles a grant is held while its request stays asserted. Range 1..15.

Ports:
- clk, input, 1: rising-edge clock.
- reset, input, 1: asynchronous, active-low reset.
- req, input, N_REQ: sensor requests, active-high, synchronous to clk.
- temp_en, input, 1: temperature sensing enable.
- temperature, input, TEMP_W: unsigned temperature.
- ack_alarm, input, 1: alarm acknowledge. Used only with STICKY_ALARM_EN; otherwise ignored.
- grant_oh, output, N_CH = N_REQ+2: registered one-hot grant. Bits N_REQ and N_REQ+1 are heater and cooler.
- code, output, CODE_W = clog2(N_CH+1): registered code. 0 = idle; k+1 = channel k granted.
- rev_mode, output, 1: current priority direction (activity counter MSB).

Behaviour:
- Channel vector: ch = {cool_req, heat_req, req}. heat_req and cool_req come from combinational comparisons. Both are 0 when temp_en=0.
- Reset (reset=0, asynchronous): grant_oh=0, code=0, rev_mode=0, activity counter=0, hold counter=0.
- Activity counter: increments on each edge where |ch=1. Wraps from 2^PERIOD_W-1 to 0. rev_mode = counter MSB.
- Arbitration, combinational:
  - rev_mode=0: the lowest set index in ch wins.
  - rev_mode=1: the highest set index wins.
  - No request: the result is idle.
- Registered update on each rising edge:
  - If current grant is idle → load the arbitration result.
  - Else if the currently granted channel's request is deasserted → load the arbitration result (release immediately; may go idle).
  - Else if hold counter > 0 → keep the grant; decrement the hold counter.
  - Else → load the arbitration result. The same channel may win again.
- Hold counter: on loading a new non-idle channel (different from the current one), set to HOLD_CYCLES-1.
- Latency: a request stable before edge k is visible on grant_oh/code after edge k, provided no hold is blocking.
- Simultaneous events:
  - rev_mode toggles on the same edge as arbitration. That arbitration uses the pre-edge rev_mode.
  - heat_req and cool_req cannot both be true (parameter constraint).
- Invariants:
  - grant_oh is always zero or one-hot.
  - code and grant_oh are always consistent.
- Reset asserted mid-hold clears everything immediately. The first post-reset edge arbitrates fresh.

Optional Feature:
- Macro: HOME_EVENT_ARBITER_STICKY_ALARM_EN.
- Defined:
  - Channel ALARM_CH = 2 is sticky. Once granted, it stays granted regardless of req[2] and of higher-priority requests, until ack_alarm=1 is sampled.
  - On that edge, normal arbitration applies.
  - ack_alarm while the alarm is not granted has no effect.
- Undefined: channel 2 behaves like every other channel; ack_alarm is ignored.

Decomposition:
- Package home_auto_pkg:
  - CODE_IDLE constant (0).
  - ALARM_CH constant.
  - clog2 function.
  - Typedef for grant code width derivation.
- Sub-module priority_mode_counter: the activity counter, with ports clk, reset, inc, rev_mode, parameter PERIOD_W.
- Arbitration and hold logic stay in home_event_arbiter.

Test Plan:
- Reset: hold reset=0 with req=5'b11111 → grant_oh=0, code=0, rev_mode=0. Release reset → after first edge, code=1 (channel 0).
- Priority reversal: PERIOD_W=4, req=5'b00101 held continuously → codes 1 for counter 0..7. From the 9th active edge code=3 (rev_mode=1). Reverts after 16 active edges.
- Hold: HOLD_CYCLES=3. Grant ch3 (req=5'b01000), then raise req[0] next cycle → ch3 stays for 3 cycles total, then code=1. Drop req[3] mid-hold instead → re-arbitrates on the next edge.
- Temperature: temp_en=1, temperature=10 → code=N_REQ+1 (heater). temperature=31 → code=N_REQ+2 (cooler). temperature=20 → idle. temp_en=0, temperature=10 → idle.
- Sticky alarm (macro defined): req[2] pulse 1 cycle → code=3 persists despite req[0]=1. ack_alarm=1 for 1 cycle → next edge code=1.
- Reset during hold: assert reset asynchronously between edges mid-hold → outputs 0 immediately, without waiting for a clock edge.
